// File: rtl/neopixel_pkg.sv
// Shared types and 12 MHz default timing for the WS2812-class one-wire transmitter.
package neopixel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      LATCH = 2'd3
   } np_state_t;

   localparam int NP_BITS_DEF       = 24;
   localparam int NP_TBIT_CYC_DEF   = 15;
   localparam int NP_T0H_CYC_DEF    = 5;
   localparam int NP_T1H_CYC_DEF    = 10;
   localparam int NP_TLATCH_CYC_DEF = 960;

   // Nearest whole number of clock cycles covering ns nanoseconds at clk_hz.
   function automatic int cyc_from_ns(input longint clk_hz, input longint ns);
      longint prod;
      prod = clk_hz * ns + longint'(500_000_000);
      return int'(prod / longint'(1_000_000_000));
   endfunction

endpackage

// File: rtl/neopixel_tx.sv
// Serialises pixel words MSB-first onto a one-wire LED line with cycle-exact
// high/low pulse widths, gapless word streaming and a latch gap after `last`.
module neopixel_tx
   import neopixel_pkg::*;
#(
   parameter int BITS       = NP_BITS_DEF,
   parameter int TBIT_CYC   = NP_TBIT_CYC_DEF,
   parameter int T0H_CYC    = NP_T0H_CYC_DEF,
   parameter int T1H_CYC    = NP_T1H_CYC_DEF,
   parameter int TLATCH_CYC = NP_TLATCH_CYC_DEF
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic [BITS-1:0] data,
   input  logic            valid,
   input  logic            last,
   output logic            ready,
   output logic            d_out,
   output logic            busy
);

   localparam int IDX_W = $clog2(BITS + 1);
   localparam int CNT_W = $clog2(TLATCH_CYC + 1);

   localparam logic [CNT_W-1:0] T0H_END   = CNT_W'(T0H_CYC - 1);
   localparam logic [CNT_W-1:0] T1H_END   = CNT_W'(T1H_CYC - 1);
   localparam logic [CNT_W-1:0] TBIT_END  = CNT_W'(TBIT_CYC - 1);
   localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(TLATCH_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BITS - 1);

   if (!(BITS >= 1 && T0H_CYC >= 1 && T0H_CYC < T1H_CYC &&
         T1H_CYC < TBIT_CYC && TLATCH_CYC >= TBIT_CYC)) begin : g_illegal
      $error("neopixel_tx: illegal BITS/timing parameter set");
   end

   np_state_t        state, state_n;
   logic [BITS-1:0]  shreg, shreg_n;
   logic [IDX_W-1:0] bit_idx, bit_idx_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             last_q, last_q_n;
   logic [CNT_W-1:0] th_end;
   logic             accept;

   // The next word may only enter while idle or on the final cycle of a
   // non-last word, which is what makes back-to-back words gapless.
   assign ready  = (state == IDLE) ||
                   (state == LOW && bit_idx == IDX_LAST && cnt == TBIT_END && !last_q);
   assign accept = valid && ready;
   assign busy   = (state != IDLE);
   assign th_end = shreg[BITS-1] ? T1H_END : T0H_END;

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_idx_n = bit_idx;
      cnt_n     = cnt;
      last_q_n  = last_q;

      case (state)
         HIGH: begin
            cnt_n = cnt + 1'b1;
            if (cnt == th_end) state_n = LOW;
         end
         LOW: begin
            if (cnt == TBIT_END) begin
               if (bit_idx != IDX_LAST) begin
                  shreg_n   = shreg << 1;
                  bit_idx_n = bit_idx + 1'b1;
                  cnt_n     = '0;
                  state_n   = HIGH;
               end else if (last_q) begin
                  cnt_n   = '0;
                  state_n = LATCH;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         LATCH: begin
            if (cnt == LATCH_END) state_n = IDLE;
            else                  cnt_n   = cnt + 1'b1;
         end
         default: ;
      endcase

      // A transfer wins over the end-of-word decision above.
      if (accept) begin
         shreg_n   = data;
         last_q_n  = last;
         bit_idx_n = '0;
         cnt_n     = '0;
         state_n   = HIGH;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         cnt     <= '0;
         last_q  <= 1'b0;
         d_out   <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_idx <= bit_idx_n;
         cnt     <= cnt_n;
         last_q  <= last_q_n;
         d_out   <= (state_n == HIGH);
      end
   end

endmodule

// File: tb/tb_neopixel_tx.sv
// Scoreboard bench for neopixel_tx: default 24-bit instance plus a 32-bit timing variant.
module tb_neopixel_tx;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [23:0] data;
   logic        valid, last;
   logic        ready, d_out, busy;
   logic [31:0] data32;
   logic        valid32, last32;
   logic        ready32, d_out32, busy32;

   always #5 CLK = ~CLK;

   neopixel_tx u_dut (
      .CLK(CLK), .RSTN(RSTN), .data(data), .valid(valid), .last(last),
      .ready(ready), .d_out(d_out), .busy(busy)
   );

   neopixel_tx #(
      .BITS(32), .TBIT_CYC(20), .T0H_CYC(6), .T1H_CYC(13), .TLATCH_CYC(100)
   ) u_dut32 (
      .CLK(CLK), .RSTN(RSTN), .data(data32), .valid(valid32), .last(last32),
      .ready(ready32), .d_out(d_out32), .busy(busy32)
   );

   typedef struct {
      int hi;
      int lo;
      bit exact;
   } exp_t;

   typedef struct {
      bit   prev;
      int   hi;
      int   lo;
      bit   have;
      exp_t cur;
   } mon_t;

   exp_t q0[$];
   exp_t q1[$];
   mon_t m0, m1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_pulses = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic mon_t mon_zero();
      mon_t z;
      z.prev = 1'b0; z.hi = 0; z.lo = 0; z.have = 1'b0;
      z.cur.hi = 0; z.cur.lo = 0; z.cur.exact = 1'b0;
      return z;
   endfunction

   function automatic logic rdy(input int id);
      return (id == 0) ? ready : ready32;
   endfunction

   function automatic logic bsy(input int id);
      return (id == 0) ? busy : busy32;
   endfunction

   function automatic logic dout(input int id);
      return (id == 0) ? d_out : d_out32;
   endfunction

   // Expected pulse list for one word: high width from the bit value, low width
   // to the end of the bit; the final bit's low run is open-ended unless the next
   // word follows gaplessly, and includes the latch gap after a last word.
   task automatic push_word(input int id, input logic [31:0] w, input int nbits,
                            input bit lst, input bit gapless, input int tbit,
                            input int t0, input int t1, input int tl);
      exp_t e;
      for (int i = nbits - 1; i >= 0; i--) begin
         e.hi    = w[i] ? t1 : t0;
         e.lo    = tbit - e.hi;
         e.exact = 1'b1;
         if (i == 0 && !gapless) begin
            e.exact = 1'b0;
            if (lst) e.lo = e.lo + tl;
         end
         if (id == 0) q0.push_back(e);
         else         q1.push_back(e);
      end
   endtask

   task automatic mon_step(input int id, input logic d, input mon_t mi, output mon_t mo);
      exp_t e;
      mo = mi;
      if (d === 1'b1) begin
         if (!mi.prev) begin
            if (mi.have) begin
               chk($sformatf("dut%0d low width before next pulse", id), mi.lo, mi.cur.lo);
               mo.have = 1'b0;
            end
            mo.hi = 1;
         end else begin
            mo.hi = mi.hi + 1;
         end
      end else if (mi.prev) begin
         if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected pulse: high %0d cycles, none queued", id, mi.hi);
            mo.have = 1'b0;
         end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d high width", id), mi.hi, e.hi);
            mo.cur  = e;
            mo.have = 1'b1;
            mo.lo   = 1;
         end
      end else if (mi.have) begin
         mo.lo = mi.lo + 1;
         if (!mi.cur.exact && mo.lo == mi.cur.lo) begin
            chk($sformatf("dut%0d trailing low run", id), mo.lo, mi.cur.lo);
            mo.have = 1'b0;
         end
      end
      mo.prev = d;
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   initial forever begin
      @(negedge CLK);
      if (ready && busy) rdy_pulses++;
   end

   // Monitor: decodes both serial lines into pulses and scores them against the queues.
   initial begin
      mon_t nx;
      m0 = mon_zero();
      m1 = mon_zero();
      forever begin
         @(negedge CLK);
         if (!RSTN) begin
            m0 = mon_zero();
            m1 = mon_zero();
         end else begin
            mon_step(0, d_out, m0, nx);
            m0 = nx;
            mon_step(1, d_out32, m1, nx);
            m1 = nx;
         end
      end
   end

   task automatic send(input int id, input logic [31:0] w, input bit lst,
                       input bit gapless, output int acc_t);
      int n;
      n = 0;
      if (id == 0) begin data = w[23:0]; last = lst; valid = 1'b1; end
      else         begin data32 = w; last32 = lst; valid32 = 1'b1; end
      while (!rdy(id) && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      if (!rdy(id)) begin
         checks++;
         errors++;
         $display("FAIL dut%0d send timeout: ready low for %0d cycles", id, n);
         acc_t = cyc;
         return;
      end
      @(posedge CLK);
      if (id == 0) push_word(0, w, 24, lst, gapless, 15, 5, 10, 960);
      else         push_word(1, w, 32, lst, gapless, 20, 6, 13, 100);
      #1;
      acc_t = cyc;
      chk($sformatf("dut%0d d_out right after transfer", id), dout(id), 1);
      @(negedge CLK);
   endtask

   task automatic wait_end(input int id, input int t, input int total);
      while (cyc < t + total - 1) @(negedge CLK);
      chk($sformatf("dut%0d ready one cycle before frame end", id), rdy(id), 0);
      chk($sformatf("dut%0d busy one cycle before frame end", id), bsy(id), 1);
      @(negedge CLK);
      chk($sformatf("dut%0d ready at frame end", id), rdy(id), 1);
      chk($sformatf("dut%0d busy at frame end", id), bsy(id), 0);
      chk($sformatf("dut%0d d_out at frame end", id), dout(id), 0);
   endtask

   initial begin
      int ta, tb, tc, t3, viol, n;
      logic [23:0] w;
      RSTN = 1'b0;
      valid = 1'b0; data = '0; last = 1'b0;
      valid32 = 1'b0; data32 = '0; last32 = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset ready", ready, 1);
      chk("reset busy", busy, 0);
      chk("reset d_out", d_out, 0);
      chk("reset d_out32", d_out32, 0);
      RSTN = 1'b1;
      @(negedge CLK);

      // Single word with latch: 24*15 bit cycles + 960 latch cycles.
      send(0, 32'h800001, 1'b1, 1'b0, ta);
      valid = 1'b0;
      wait_end(0, ta, 1320);

      // Gapless stream of three words.
      rdy_pulses = 0;
      send(0, 32'hFFFFFF, 1'b0, 1'b1, ta);
      send(0, 32'h000000, 1'b0, 1'b1, tb);
      send(0, 32'hA5A5A5, 1'b1, 1'b0, tc);
      valid = 1'b0;
      chk("stream word spacing 1-2", tb - ta, 360);
      chk("stream word spacing 2-3", tc - tb, 360);
      wait_end(0, tc, 1320);
      chk("stream ready boundary pulses", rdy_pulses, 2);

      // Stall: non-last word, then 100 idle cycles.
      send(0, 32'h123456, 1'b0, 1'b0, ta);
      valid = 1'b0;
      while (cyc < ta + 360) @(negedge CLK);
      viol = 0;
      for (int i = 0; i < 100; i++) begin
         if (d_out !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) viol++;
         @(negedge CLK);
      end
      chk("stall idle violations", viol, 0);
      send(0, 32'h00FF00, 1'b1, 1'b0, ta);
      valid = 1'b0;
      wait_end(0, ta, 1320);

      // Backpressure: data changes every cycle while valid stays high.
      n = 0;
      t3 = 0;
      for (int i = 0; i < 2000 && n < 3; i++) begin
         w = 24'h5A0000 ^ 24'(i * 32'h010203);
         data = w; last = (n == 2); valid = 1'b1;
         if (ready) begin
            @(posedge CLK);
            push_word(0, {8'h00, w}, 24, n == 2, n < 2, 15, 5, 10, 960);
            #1;
            t3 = cyc;
            n++;
         end
         @(negedge CLK);
      end
      valid = 1'b0;
      chk("backpressure words accepted", n, 3);
      wait_end(0, t3, 1320);

      // Reset in the 5th cycle of bit 12's high phase (bit 12 of 3C5A96 is 1).
      send(0, 32'h3C5A96, 1'b0, 1'b0, ta);
      valid = 1'b0;
      while (cyc < ta + 169) @(negedge CLK);
      chk("d_out high before mid-word reset", d_out, 1);
      RSTN = 1'b0;
      q0.delete();
      #1;
      chk("d_out falls on async reset", d_out, 0);
      chk("ready during reset", ready, 1);
      chk("busy during reset", busy, 0);
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      viol = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (d_out !== 1'b0 || ready !== 1'b1) viol++;
      end
      chk("no residual bits after reset", viol, 0);

      // 32-bit variant: 28 zero pulses, 4 one pulses, 100 latch cycles.
      send(1, 32'h0000000F, 1'b1, 1'b0, ta);
      valid32 = 1'b0;
      wait_end(1, ta, 740);

      @(negedge CLK);
      chk("dut0 expected pulses left over", q0.size(), 0);
      chk("dut1 expected pulses left over", q1.size(), 0);
      chk("dut0 pulse still open", m0.have, 0);
      chk("dut1 pulse still open", m1.have, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
